// File: rtl/period_timer_pkg.sv
// Shared types and helpers for the programmable period timer.
package period_timer_pkg;

    // Controller states; the encoding lives here so the timer and any
    // observers agree on it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Terminal count of a WIDTH-bit up-counter (all ones). Valid for WIDTH <= 63.
    function automatic longint unsigned max_count(input int width);
        return (longint'(1) << width) - 1;
    endfunction

endpackage

// File: rtl/period_timer_ctrl_count_slice.sv
// Chainable, loadable up-counter slice: reset beats load, load beats count.
module count_slice #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic             en,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] pi,
    output logic [WIDTH-1:0] po,
    output logic             carry_out
);

    // Counter register: synchronous reset, then parallel load, then increment.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values, independent of block ordering.
        if (rst) begin
            po <= '0;
        end else if (ld) begin
            po <= pi;
        end else if (en && carry_in) begin
            po <= po + 1'b1;
        end
    end

    // Ripple carry to the next slice: this slice is at all-ones and counting.
    assign carry_out = en & carry_in & (&po);

endmodule

// File: rtl/period_timer_ctrl.sv
// Period timer controller: sequences a count_slice through load, run and
// terminal-count handling in one-shot or auto-reload mode.
module period_timer_ctrl
    import period_timer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             periodic,
    input  logic [WIDTH-1:0] preset,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tick,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(max_count(WIDTH));

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] preset_q;
    logic             mode_q;
    logic             capture;

    logic             slice_ld;
    logic             slice_en;
    logic             slice_ci;
    logic [WIDTH-1:0] slice_pi;
    logic             carry_out;

    // Counting is enabled only in RUN and not when aborting; kept outside the
    // FSM block because carry_out feeds back into it.
    assign slice_en = (state == RUN) && !stop;
    assign slice_ci = ~hold;

    count_slice #(.WIDTH(WIDTH)) u_slice (
        .clk       (clk),
        .rst       (rst),
        .ld        (slice_ld),
        .en        (slice_en),
        .carry_in  (slice_ci),
        .pi        (slice_pi),
        .po        (count),
        .carry_out (carry_out)
    );

    // State register, captured run parameters and the registered tick pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            preset_q <= '0;
            mode_q   <= 1'b0;
            tick     <= 1'b0;
        end else begin
            state <= next_state;
            tick  <= carry_out;
            if (capture) begin
                preset_q <= preset;
                mode_q   <= periodic;
            end
        end
    end

    // Next-state decode and slice load control.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        next_state = state;
        capture    = 1'b0;
        slice_ld   = 1'b0;
        slice_pi   = preset_q;

        unique case (state)
            IDLE: begin
                if (start && !stop) begin
                    capture    = 1'b1;
                    next_state = LOAD;
                end
            end
            LOAD: begin
                // The load completes even when the run is aborted here.
                slice_ld   = 1'b1;
                next_state = stop ? IDLE : RUN;
            end
            RUN: begin
                if (stop) begin
                    next_state = IDLE;
                end else if (carry_out) begin
                    slice_ld = 1'b1;
                    if (!mode_q) begin
                        // Reload MAX so the count parks at terminal instead of wrapping.
                        slice_pi   = MAX;
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_period_timer_ctrl.sv
// Self-checking bench for period_timer_ctrl (WIDTH = 8).
module tb_period_timer_ctrl;

    localparam int WIDTH = 8;

    typedef struct {
        logic       rst;
        logic       start;
        logic       stop;
        logic       hold;
        logic       periodic;
        logic [7:0] preset;
        logic [7:0] exp_count;
        logic       exp_busy;
        logic       exp_tick;
        logic       exp_done;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       hold;
    logic       periodic;
    logic [7:0] preset;
    logic [7:0] count;
    logic       busy;
    logic       tick;
    logic       done;

    int n_vec = 0;
    int n_err = 0;

    vec_t vecs[$];

    always #5 clk = ~clk;

    period_timer_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .hold     (hold),
        .periodic (periodic),
        .preset   (preset),
        .count    (count),
        .busy     (busy),
        .tick     (tick),
        .done     (done)
    );

    function automatic vec_t mk(input logic r, input logic s, input logic p,
                                input logic h, input logic m, input logic [7:0] pr,
                                input logic [7:0] ec, input logic eb,
                                input logic et, input logic ed);
        vec_t v;
        v.rst = r; v.start = s; v.stop = p; v.hold = h; v.periodic = m;
        v.preset = pr; v.exp_count = ec; v.exp_busy = eb;
        v.exp_tick = et; v.exp_done = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let one edge pass, compare the outputs.
    task automatic run_vec(input vec_t v, input string tag);
        rst      = v.rst;
        start    = v.start;
        stop     = v.stop;
        hold     = v.hold;
        periodic = v.periodic;
        preset   = v.preset;
        @(posedge clk);
        #1;
        check({tag, ".count"}, 32'(count), 32'(v.exp_count));
        check({tag, ".busy"},  32'(busy),  32'(v.exp_busy));
        check({tag, ".tick"},  32'(tick),  32'(v.exp_tick));
        check({tag, ".done"},  32'(done),  32'(v.exp_done));
    endtask

    initial begin
        int cycles;
        bit seen;

        rst = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0;
        periodic = 1'b0; preset = 8'h00;

        // ---------------- vector table ----------------
        // Reset state.
        vecs.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 1, 8'h55, 8'h00, 0, 0, 0));
        // One-shot, preset FC: E0 LOAD, E1 FC .. E4 FF, E5 tick+done, E6 idle.
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'hFC, 8'h00, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 8'h00, 8'hFC, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 8'h00, 8'hFD, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'hFE, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'hFF, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'hFF, 1, 1, 1));
        // start during DONE is ignored.
        vecs.push_back(mk(0, 1, 0, 0, 0, 8'h10, 8'hFF, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h10, 8'hFF, 0, 0, 0));
        // Periodic, preset F8: count F8..FF, tick with count=F8 every 8 edges.
        vecs.push_back(mk(0, 1, 0, 0, 1, 8'hF8, 8'hFF, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'hF8, 1, 0, 0));
        for (int lap = 0; lap < 2; lap++) begin
            for (int k = 1; k < 8; k++)
                vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'(8'hF8 + k), 1, 0, 0));
            vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'hF8, 1, 1, 0));
        end
        for (int k = 1; k < 8; k++)
            vecs.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'(8'hF8 + k), 1, 0, 0));
        // stop + start while count==FF: no tick, idle, count frozen, no new run.
        vecs.push_back(mk(0, 1, 1, 0, 1, 8'h20, 8'hFF, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 8'h20, 8'hFF, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 8'h20, 8'hFF, 0, 0, 0));

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // ---------------- hold at FE, periodic F8 ----------------
        run_vec(mk(0, 1, 0, 0, 1, 8'hF8, 8'hFF, 1, 0, 0), "hold_start");
        run_vec(mk(0, 0, 0, 0, 0, 8'h00, 8'hF8, 1, 0, 0), "hold_load");
        for (int k = 1; k <= 6; k++)
            run_vec(mk(0, 0, 0, 0, 0, 8'h00, 8'(8'hF8 + k), 1, 0, 0), $sformatf("hold_run%0d", k));
        // count is FE now; freeze it for three edges.
        for (int k = 0; k < 3; k++)
            run_vec(mk(0, 0, 0, 1, 0, 8'h00, 8'hFE, 1, 0, 0), $sformatf("hold_frz%0d", k));
        // Unheld, FE reaches tick in 2 edges; so 2 more after releasing.
        hold = 1'b0;
        cycles = 0;
        seen = 1'b0;
        while (!seen && cycles < 10) begin
            @(posedge clk);
            #1;
            cycles++;
            seen = tick;
        end
        check("hold_tick_delay", 32'(cycles), 32'd2);
        check("hold_reload", 32'(count), 32'hF8);

        // ---------------- start during RUN with preset 00 ----------------
        for (int k = 1; k < 8; k++)
            run_vec(mk(0, 1, 0, 0, 0, 8'h00, 8'(8'hF8 + k), 1, 0, 0), $sformatf("rerun%0d", k));
        run_vec(mk(0, 1, 0, 0, 0, 8'h00, 8'hF8, 1, 1, 0), "rerun_reload");
        run_vec(mk(0, 0, 1, 0, 0, 8'h00, 8'hF8, 0, 0, 0), "rerun_stop");

        // ---------------- rst mid-run at pending terminal ----------------
        run_vec(mk(0, 1, 0, 0, 0, 8'hFE, 8'hF8, 1, 0, 0), "rst_start");
        run_vec(mk(0, 0, 0, 0, 0, 8'hFE, 8'hFE, 1, 0, 0), "rst_load");
        run_vec(mk(0, 0, 0, 0, 0, 8'hFE, 8'hFF, 1, 0, 0), "rst_run");
        run_vec(mk(1, 0, 0, 0, 0, 8'hFE, 8'h00, 0, 0, 0), "rst_hit");
        run_vec(mk(0, 0, 0, 0, 0, 8'hFF, 8'h00, 0, 0, 0), "rst_idle");
        // One-shot with preset MAX: one RUN cycle then tick and done.
        run_vec(mk(0, 1, 0, 0, 0, 8'hFF, 8'h00, 1, 0, 0), "max_start");
        run_vec(mk(0, 0, 0, 0, 0, 8'hFF, 8'hFF, 1, 0, 0), "max_load");
        run_vec(mk(0, 0, 0, 0, 0, 8'hFF, 8'hFF, 1, 1, 1), "max_done");
        run_vec(mk(0, 0, 0, 0, 0, 8'hFF, 8'hFF, 0, 0, 0), "max_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
